// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MIPS mult/multu/div/divu unit owning HI/LO
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 sign_a, sign_b;
    logic [1:0]           op_r;
    logic                 dz;

    logic                 b_zero;
    logic                 in_sa, in_sb;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh, trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     res_hi, res_lo;

    // op[0] set means unsigned; op[1] set means divide
    assign b_zero = (b == '0);
    assign in_sa  = ~op[0] & a[WIDTH-1];
    assign in_sb  = ~op[0] & b[WIDTH-1];
    assign mag_a  = in_sa ? (~a + 1'b1) : a;
    assign mag_b  = in_sb ? (~b + 1'b1) : b;

    // acc holds {partial product, remaining multiplier}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // acc holds {partial remainder, dividend shifting into quotient}
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign trial    = rem_sh - {1'b0, opnd};
    assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_neg = ~acc + 1'b1;

    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
        if (!op_r[0]) begin
            if (!op_r[1]) begin
                if (sign_a ^ sign_b) begin
                    res_hi = prod_neg[2*WIDTH-1:WIDTH];
                    res_lo = prod_neg[WIDTH-1:0];
                end
            end else begin
                if (sign_a ^ sign_b) res_lo = ~acc[WIDTH-1:0] + 1'b1;
                if (sign_a)          res_hi = ~acc[2*WIDTH-1:WIDTH] + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (op[1] && b_zero) ? FIX : CALC;
            CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            op_r        <= '0;
            dz          <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state       <= state_nxt;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        sign_a <= in_sa;
                        sign_b <= in_sb;
                        dz     <= op[1] & b_zero;
                        cnt    <= CNT_W'(WIDTH);
                        opnd   <= op[1] ? mag_b : mag_a;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    acc <= op_r[1] ? div_next : mul_next;
                end
                FIX: begin
                    done <= 1'b1;
                    if (dz) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - directed bench for mips_muldiv_unit (32- and 8-bit instances)
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wr_data = '0;
    logic        wr_hi = 1'b0, wr_lo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0, wr_data8 = '0;
    logic        wr_hi8 = 1'b0, wr_lo8 = 1'b0;
    logic        busy8, done8, div_by_zero8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;
    int lat, busy_n, done_n;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    mips_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wr_data(wr_data8),
        .busy(busy8), .done(done8), .div_by_zero(div_by_zero8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; returns edges from E0 to done and busy samples from E0 on
    task automatic run32(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         output int l, output int bn);
        start = 1'b1; op = o; a = aa; b = bb;
        tick();
        start = 1'b0;
        l = 0;
        bn = busy ? 1 : 0;
        while (!done && l < 100) begin
            tick();
            l++;
            if (busy) bn++;
        end
        if (!done) check("timeout32", 0, 1);
    endtask

    initial begin
        tick(); tick(); tick();
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        tick();

        // 1: multu max*max
        run32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy_n);
        check("t1_lat", lat, 33);
        check("t1_busy_n", busy_n, 33);
        check("t1_busy_at_done", busy, 0);
        check("t1_hi", hi, 32'hFFFFFFFE);
        check("t1_lo", lo, 32'h00000001);
        tick();
        check("t1_done_pulse", done, 0);

        // 2: signed multiplies
        run32(OP_MULT, 32'hFFFFFFFD, 32'd5, lat, busy_n);
        check("t2a_hi", hi, 32'hFFFFFFFF);
        check("t2a_lo", lo, 32'hFFFFFFF1);
        tick();
        run32(OP_MULT, 32'h80000000, 32'h80000000, lat, busy_n);
        check("t2b_hi", hi, 32'h40000000);
        check("t2b_lo", lo, 32'h0);
        tick();

        // 3: divides
        run32(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, busy_n);
        check("t3a_lo", lo, 32'hFFFFFFFD);
        check("t3a_hi", hi, 32'hFFFFFFFF);
        tick();
        run32(OP_DIVU, 32'd7, 32'd2, lat, busy_n);
        check("t3b_lo", lo, 32'd3);
        check("t3b_hi", hi, 32'd1);
        check("t3b_lat", lat, 33);
        tick();
        run32(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, busy_n);
        check("t3c_lo", lo, 32'hFFFFFFFD);
        check("t3c_hi", hi, 32'd1);
        tick();
        run32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, busy_n);
        check("t3d_lo", lo, 32'h80000000);
        check("t3d_hi", hi, 32'd0);
        tick();

        // 4: mthi/mtlo then divide by zero
        wr_hi = 1'b1; wr_data = 32'h1234; tick();
        wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5678; tick();
        wr_lo = 1'b0;
        check("t4_pre_hi", hi, 32'h1234);
        check("t4_pre_lo", lo, 32'h5678);
        run32(OP_DIVU, 32'd5, 32'd0, lat, busy_n);
        check("t4_lat", lat, 1);
        check("t4_busy_n", busy_n, 1);
        check("t4_dbz", div_by_zero, 1);
        check("t4_hi", hi, 32'h1234);
        check("t4_lo", lo, 32'h5678);
        tick();
        check("t4_dbz_pulse", div_by_zero, 0);
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hABCD; tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("t4_both_hi", hi, 32'hABCD);
        check("t4_both_lo", lo, 32'hABCD);

        // 5: start and mtlo while busy are ignored
        start = 1'b1; op = OP_MULTU; a = 32'd100; b = 32'd200;
        tick();
        start = 1'b0;
        lat = 0;
        repeat (5) begin tick(); lat++; end
        start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
        wr_lo = 1'b1; wr_data = 32'hDEAD;
        tick(); lat++;
        start = 1'b0; wr_lo = 1'b0;
        check("t5_lo_mid", lo, 32'hABCD);
        while (!done && lat < 100) begin tick(); lat++; end
        check("t5_lat", lat, 33);
        check("t5_hi", hi, 32'd0);
        check("t5_lo", lo, 32'd20000);
        tick();

        // 5b: reset during CALC
        start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'h3;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("t5r_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("t5r_busy", busy, 0);
        check("t5r_hi", hi, 0);
        check("t5r_lo", lo, 0);
        tick();
        rst = 1'b0;
        done_n = 0;
        repeat (40) begin tick(); if (done) done_n++; end
        check("t5r_no_done", done_n, 0);

        // 6: 8-bit signed most-negative / -1, then back-to-back start on the done cycle
        start8 = 1'b1; op8 = OP_DIV; a8 = 8'h80; b8 = 8'hFF;
        tick();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 50) begin tick(); lat++; end
        check("t6_lat", lat, 9);
        check("t6_lo", lo8, 8'h80);
        check("t6_hi", hi8, 8'h00);
        start8 = 1'b1; op8 = OP_DIVU; a8 = 8'd200; b8 = 8'd7;
        tick();
        start8 = 1'b0;
        check("t6b_busy", busy8, 1);
        lat = 0;
        while (!done8 && lat < 50) begin tick(); lat++; end
        check("t6b_lat", lat, 9);
        check("t6b_lo", lo8, 8'd28);
        check("t6b_hi", hi8, 8'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit. It executes MIPS mult, multu, div and divu and owns the HI/LO register pair.
- Sits beside the combinational ALU in the execute stage. The ALU covers single-cycle ops; this block covers multi-cycle ops, so the pipeline stalls on busy.
- Radix-2 shift-add multiply and restoring divide; signed ops go through a magnitude datapath with a final sign-fix cycle.
- Also supports direct HI/LO writes (mthi/mtlo) and reads (mfhi/mflo).

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- wr_hi  in  1  mthi write strobe
- wr_lo  in  1  mtlo write strobe
- wr_data  in  WIDTH  data for mthi/mtlo
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle
- div_by_zero  out  1  one-cycle pulse, coincident with done, for a zero divisor
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, rst=1): state IDLE; hi, lo, busy, done, div_by_zero all 0; counter and work registers 0. Reset mid-operation aborts the operation with no partial write to HI/LO.
- States are IDLE, CALC, FIX.
- IDLE, start=1, nonzero divisor or any multiply:
  - On the capturing edge (E0): latch operand magnitudes, the two sign bits and op; counter = WIDTH; go to CALC; busy=1.
- CALC: one iteration per clock for exactly WIDTH clocks, counter decrements.
  - Multiply: add the multiplicand to the 2*WIDTH accumulator if the multiplier LSB is 1, then shift right.
  - Divide: shift the remainder/quotient pair left, trial-subtract, set the quotient bit if the result is non-negative.
  - On counter reaching 0, go to FIX.
- FIX, one clock:
  - Signed ops negate results per the sign rules below.
  - HI/LO are written on the edge leaving FIX (E(WIDTH+1)).
  - After that edge: done=1, busy=0, state IDLE.
- Latency: start sampled at E0, result and done visible after E(WIDTH+1). This is WIDTH+2 cycles of occupancy including the issue cycle.
- Sign rules:
  - mult: product negated when sign(a) XOR sign(b).
  - div: quotient truncates toward zero and is negated when the signs differ; remainder takes the dividend's sign.
  - Signed most-negative / -1 gives lo = most-negative, hi = 0 (natural wrap, no trap).
- Divide by zero (op 10/11, b==0):
  - E0 goes directly to FIX with busy=1; no arithmetic.
  - After E1: done=1, div_by_zero=1, busy=0.
  - HI/LO are unchanged.
- Arithmetic is unsigned modulo 2^(2*WIDTH) internally; the full 2*WIDTH product is always kept, with no overflow flag.
- start while busy=1 is ignored (no queueing). start in the same cycle as done is accepted, since the state is then IDLE.
- wr_hi/wr_lo:
  - Take effect on the next edge only when state is IDLE and start=0.
  - Ignored when busy=1 or start=1, so the operation result takes precedence.
  - wr_hi and wr_lo together write both registers.
- hi/lo are direct register outputs with no combinational path from the inputs.
- done and div_by_zero are never asserted for more than one cycle; busy and done are never high together.

Test Plan:
1. WIDTH=32, multu a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 33 cycles after the start edge; done after E33; hi=0xFFFFFFFE, lo=0x00000001.
2. mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then mult a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7 b=2 -> lo=3, hi=1; div a=7 b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
4. Preload hi=0x1234, lo=0x5678 via wr_hi/wr_lo, then divu a=5 b=0 -> done and div_by_zero both high after E1; hi/lo remain 0x1234/0x5678.
5. During busy, pulse start with different operands and pulse wr_lo=0xDEAD -> both ignored; the original result lands. Assert rst at CALC cycle 10 -> immediate busy=0, hi=lo=0, and no done afterwards.
6. WIDTH=8 instance: div a=0x80 b=0xFF -> lo=0x80, hi=0x00, done after E9; back-to-back start on the done cycle is accepted.
